// File: rtl/fixed_point_divide_seq_if.sv
// -----------------------------------------------------------------------------
// fixed_point_divide_seq_if
// Handshake bundle for the sequential Q4.11 sign-magnitude divider.
//
// Signals:
//   in_valid    upstream has operands a/b ready
//   in_ready    divider can accept operands (idle)
//   a, b        dividend / divisor, sign-magnitude
//   out_valid   quotient valid, held until out_ready
//   out_ready   downstream accepts the quotient
//   c           quotient, sign-magnitude
//   overflow    quotient magnitude saturated
//   div_by_zero divisor magnitude was zero
//   busy        divider is dividing or holding a result
//
// Modports: master = upstream/downstream side, slave = divider.
// -----------------------------------------------------------------------------
interface fixed_point_divide_seq_if #(
    parameter int BITSIZE = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [BITSIZE-1:0] a;
    logic [BITSIZE-1:0] b;
    logic               out_valid;
    logic               out_ready;
    logic [BITSIZE-1:0] c;
    logic               overflow;
    logic               div_by_zero;
    logic               busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, overflow, div_by_zero, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, overflow, div_by_zero, busy
    );
endinterface

// File: rtl/fixed_point_divide_seq.sv
// -----------------------------------------------------------------------------
// fixed_point_divide_seq
// Sequential sign-magnitude fixed-point divider: c = a / b in the same
// BITSIZE-bit format as the datapath multiplier (sign bit, then magnitude
// with FRAC fraction bits). Restoring division, one quotient bit per cycle,
// ITER = BITSIZE-1+FRAC iterations. Oversized quotients saturate, a zero
// divisor magnitude yields a saturated result with div_by_zero set.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  slave side of fixed_point_divide_seq_if (valid/ready in and out,
//        operands, quotient, overflow, div_by_zero, busy)
// -----------------------------------------------------------------------------
module fixed_point_divide_seq #(
    parameter int BITSIZE = 16,
    parameter int FRAC    = 11
) (
    input  logic                     clk,
    input  logic                     rst,
    fixed_point_divide_seq_if.slave  bus
);
    localparam int MAGW = BITSIZE - 1;
    localparam int ITER = MAGW + FRAC;
    localparam int CNTW = $clog2(ITER + 1);

    typedef enum logic [1:0] {IDLE, DIV, DONE} state_t;

    state_t            state_q, state_d;
    logic              sign_q, sign_d;
    logic [MAGW-1:0]   mag_b_q, mag_b_d;
    logic [ITER-1:0]   dividend_q, dividend_d;
    logic [ITER-1:0]   quot_q, quot_d;
    logic [MAGW:0]     rem_q, rem_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic [BITSIZE-1:0] c_q, c_d;
    logic              overflow_q, overflow_d;
    logic              dbz_q, dbz_d;
    logic              out_valid_q, out_valid_d;

    logic [MAGW:0]     rem_shift;
    logic [MAGW:0]     rem_next;
    logic              q_bit;
    logic [ITER-1:0]   quot_next;
    logic              res_ovf;
    logic [MAGW-1:0]   res_mag;
    logic              res_sign;

    // State register: all flops, cleared synchronously
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sign_q      <= 1'b0;
            mag_b_q     <= '0;
            dividend_q  <= '0;
            quot_q      <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            c_q         <= '0;
            overflow_q  <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sign_q      <= sign_d;
            mag_b_q     <= mag_b_d;
            dividend_q  <= dividend_d;
            quot_q      <= quot_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            c_q         <= c_d;
            overflow_q  <= overflow_d;
            dbz_q       <= dbz_d;
            out_valid_q <= out_valid_d;
        end
    end

    // One restoring step plus result formation from the quotient that
    // includes this cycle's bit. The remainder stays below mag_b, so the
    // shifted value always fits in MAGW+1 bits.
    always_comb begin
        rem_shift = {rem_q[MAGW-1:0], dividend_q[ITER-1]};
        q_bit     = (rem_shift >= {1'b0, mag_b_q});
        rem_next  = q_bit ? (rem_shift - {1'b0, mag_b_q}) : rem_shift;
        quot_next = {quot_q[ITER-2:0], q_bit};
        res_ovf   = |quot_next[ITER-1:MAGW];
        res_mag   = res_ovf ? '1 : quot_next[MAGW-1:0];
        // A zero magnitude is never given a negative sign
        res_sign  = sign_q & (res_ovf | (res_mag != '0));
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        sign_d      = sign_q;
        mag_b_d     = mag_b_q;
        dividend_d  = dividend_q;
        quot_d      = quot_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        c_d         = c_q;
        overflow_d  = overflow_q;
        dbz_d       = dbz_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d  = bus.a[BITSIZE-1] ^ bus.b[BITSIZE-1];
                    mag_b_d = bus.b[MAGW-1:0];
                    if (bus.b[MAGW-1:0] == '0) begin
                        // Zero divisor: saturate with the dividend's sign
                        state_d     = DONE;
                        c_d         = {bus.a[BITSIZE-1], {MAGW{1'b1}}};
                        overflow_d  = 1'b0;
                        dbz_d       = 1'b1;
                        out_valid_d = 1'b1;
                    end else begin
                        state_d    = DIV;
                        dividend_d = {bus.a[MAGW-1:0], {FRAC{1'b0}}};
                        rem_d      = '0;
                        quot_d     = '0;
                        cnt_d      = CNTW'(ITER);
                    end
                end
            end
            DIV: begin
                rem_d      = rem_next;
                quot_d     = quot_next;
                dividend_d = {dividend_q[ITER-2:0], 1'b0};
                cnt_d      = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    state_d     = DONE;
                    c_d         = {res_sign, res_mag};
                    overflow_d  = res_ovf;
                    dbz_d       = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs: handshake status decodes from state, results are registered
    always_comb begin
        bus.in_ready    = (state_q == IDLE);
        bus.busy        = (state_q != IDLE);
        bus.out_valid   = out_valid_q;
        bus.c           = c_q;
        bus.overflow    = overflow_q;
        bus.div_by_zero = dbz_q;
    end
endmodule

// File: tb/tb_fixed_point_divide_seq.sv
// -----------------------------------------------------------------------------
// tb_fixed_point_divide_seq
// Self-checking bench for fixed_point_divide_seq. Expected quotients come
// from an integer-division model and travel through a scoreboard queue from
// the stimulus side to the result side.
// -----------------------------------------------------------------------------
module tb_fixed_point_divide_seq;
    logic clk;
    logic rst;
    int   cycle;
    int   errors;
    int   checks;

    typedef struct {
        logic [15:0] c;
        logic        ovf;
        logic        dbz;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];

    fixed_point_divide_seq_if #(.BITSIZE(16)) dif ();

    fixed_point_divide_seq #(.BITSIZE(16), .FRAC(11)) dut (
        .clk (clk),
        .rst (rst),
        .bus (dif.slave)
    );

    // Free-running clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle = cycle + 1;

    // Reference model: exact integer division of magA*2^11 by magB,
    // truncated, saturated to 15 bits, no negative zero. Latency counts
    // clock edges after the acceptance edge until out_valid is seen.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t   e;
        longint q;
        logic   sgn;
        sgn = a[15] ^ b[15];
        e.acc = 0;
        if (b[14:0] == 15'd0) begin
            e.c   = {a[15], 15'h7FFF};
            e.ovf = 1'b0;
            e.dbz = 1'b1;
            e.lat = 0;
        end else begin
            q = (longint'(a[14:0]) * 2048) / longint'(b[14:0]);
            e.dbz = 1'b0;
            e.lat = 26;
            if (q > 32767) begin
                e.c   = {sgn, 15'h7FFF};
                e.ovf = 1'b1;
            end else begin
                e.c   = {sgn & (q != 0), q[14:0]};
                e.ovf = 1'b0;
            end
        end
        return e;
    endfunction

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Wait (bounded) for in_ready, present operands for one edge, and
    // optionally push the model's answer onto the scoreboard
    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b,
                                 input bit pushExp);
        int   n;
        exp_t e;
        n = 0;
        while (!dif.in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (!dif.in_ready) begin
            checkOutput("in_ready_timeout", 32'(dif.in_ready), 32'd1);
            return;
        end
        dif.a        = a;
        dif.b        = b;
        dif.in_valid = 1'b1;
        @(negedge clk);
        dif.in_valid = 1'b0;
        checkOutput("busy_after_accept", 32'(dif.busy), 32'd1);
        if (pushExp) begin
            e     = model(a, b);
            e.acc = cycle;
            sb.push_back(e);
        end
    endtask

    // Wait (bounded) for out_valid, pop the scoreboard and compare
    task automatic collectResult();
        int   n;
        exp_t e;
        n = 0;
        while (!dif.out_valid && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            checkOutput("scoreboard_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        if (!dif.out_valid) begin
            checkOutput("out_valid_timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("c", 32'(dif.c), 32'(e.c));
        checkOutput("overflow", 32'(dif.overflow), 32'(e.ovf));
        checkOutput("div_by_zero", 32'(dif.div_by_zero), 32'(e.dbz));
        checkOutput("latency", 32'(cycle - e.acc), 32'(e.lat));
    endtask

    // With out_ready high, the result is taken on the next edge
    task automatic finishResult();
        @(negedge clk);
        checkOutput("out_valid_clear", 32'(dif.out_valid), 32'd0);
        checkOutput("in_ready_back", 32'(dif.in_ready), 32'd1);
    endtask

    task automatic runCase(input logic [15:0] a, input logic [15:0] b);
        applyStimulus(a, b, 1'b1);
        collectResult();
        finishResult();
    endtask

    initial begin
        bit          seen;
        logic [15:0] ra, rb;
        errors        = 0;
        checks        = 0;
        rst           = 1'b1;
        dif.in_valid  = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        dif.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("rst_out_valid", 32'(dif.out_valid), 32'd0);
        checkOutput("rst_c", 32'(dif.c), 32'd0);
        checkOutput("rst_overflow", 32'(dif.overflow), 32'd0);
        checkOutput("rst_div_by_zero", 32'(dif.div_by_zero), 32'd0);
        checkOutput("rst_busy", 32'(dif.busy), 32'd0);
        checkOutput("rst_in_ready", 32'(dif.in_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Directed cases: exact, signed, truncation, -0, saturation, zero divisor
        runCase(16'h1800, 16'h0C00);
        runCase(16'h9800, 16'h0C00);
        runCase(16'h0800, 16'h1800);
        runCase(16'h8000, 16'h0800);
        runCase(16'h7800, 16'h0400);
        runCase(16'hF800, 16'h0400);
        runCase(16'h8800, 16'h8000);
        runCase(16'h0000, 16'h0000);

        // Backpressure: result held, new operands refused until released
        dif.out_ready = 1'b0;
        applyStimulus(16'h1800, 16'h0C00, 1'b1);
        collectResult();
        dif.a        = 16'h0800;
        dif.b        = 16'h1800;
        dif.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_c_held", 32'(dif.c), 32'h1000);
            checkOutput("bp_out_valid_held", 32'(dif.out_valid), 32'd1);
            checkOutput("bp_flags_held", 32'({dif.overflow, dif.div_by_zero}), 32'd0);
            checkOutput("bp_in_ready_low", 32'(dif.in_ready), 32'd0);
        end
        dif.out_ready = 1'b1;
        @(negedge clk);
        checkOutput("bp_release_in_ready", 32'(dif.in_ready), 32'd1);
        checkOutput("bp_release_out_valid", 32'(dif.out_valid), 32'd0);
        begin
            exp_t e;
            @(negedge clk);
            dif.in_valid = 1'b0;
            checkOutput("bp_new_accept", 32'(dif.busy), 32'd1);
            e     = model(16'h0800, 16'h1800);
            e.acc = cycle;
            sb.push_back(e);
        end
        collectResult();
        finishResult();

        // Reset in the middle of a division aborts it without a result
        applyStimulus(16'h1800, 16'h0C00, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checkOutput("abort_in_ready", 32'(dif.in_ready), 32'd1);
        checkOutput("abort_out_valid", 32'(dif.out_valid), 32'd0);
        checkOutput("abort_c", 32'(dif.c), 32'd0);
        checkOutput("abort_busy", 32'(dif.busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            seen = seen | dif.out_valid;
        end
        checkOutput("abort_no_result", 32'(seen), 32'd0);
        runCase(16'h0800, 16'h0800);

        // Random operands, some with small divisors to reach saturation
        for (int i = 0; i < 10; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (i % 3 == 0) rb[14:8] = 7'd0;
            runCase(ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
